// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle RV32 subset datapath (lw/sw/R/I/beq/jal).
// Optional illegal-opcode trap state enabled by MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN.
module multicycle_controller #(
    parameter int unsigned FETCH_WAIT_CYCLES = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zeroFlag,
    output logic       o_pcWrite,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regWrite,
    output logic       o_adrSrc,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_immSrc,
    output logic [3:0] o_aluLogicOperation
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
    ,
    output logic       o_illegal
`endif
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] FETCH_LAST = FETCH_WAIT_CYCLES[3:0];

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
        , S_ERROR
`endif
    } state_t;

    state_t     state_q, state_d, cur;
    logic [3:0] cnt_q, cnt_d;
    logic       pc_we, mem_we, ir_we, reg_we;

    // funct7b5 only selects SUB for register-register ops
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'b000:  return sub_ok ? ALU_SUB : ALU_ADD;
            3'b100:  return ALU_XOR;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // While reset is low, decode as FETCH so selects are stable and nothing mid-flight leaks out
    assign cur = i_rst_n ? state_q : S_FETCH;

    always_comb begin
        state_d             = state_q;
        cnt_d               = '0;
        pc_we               = 1'b0;
        mem_we              = 1'b0;
        ir_we               = 1'b0;
        reg_we              = 1'b0;
        o_adrSrc            = 1'b0;
        o_resultSrc         = 2'b00;
        o_aluSrcA           = 2'b00;
        o_aluSrcB           = 2'b00;
        o_aluLogicOperation = ALU_ADD;
        case (cur)
            S_FETCH: begin
                o_aluSrcB   = 2'b10;
                o_resultSrc = 2'b10;
                if (cnt_q == FETCH_LAST) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b01;
                case (i_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
                    default:      state_d = S_ERROR;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                o_aluSrcA = 2'b10;
                o_aluSrcB = 2'b01;
                state_d   = (i_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                o_adrSrc = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                o_resultSrc = 2'b01;
                reg_we      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                o_adrSrc = 1'b1;
                mem_we   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTER: begin
                o_aluSrcA           = 2'b10;
                o_aluLogicOperation = alu_dec(i_funct3, i_funct7b5);
                state_d             = S_ALUWB;
            end
            S_EXECUTEI: begin
                o_aluSrcA           = 2'b10;
                o_aluSrcB           = 2'b01;
                o_aluLogicOperation = alu_dec(i_funct3, 1'b0);
                state_d             = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                o_aluSrcA           = 2'b10;
                o_aluLogicOperation = ALU_SUB;
                pc_we               = i_zeroFlag;
                state_d             = S_FETCH;
            end
            S_JAL: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b10;
                pc_we     = 1'b1;
                state_d   = S_ALUWB;
            end
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
            S_ERROR: state_d = S_ERROR;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (i_opcode)
            OP_SW:   o_immSrc = 2'b01;
            OP_BEQ:  o_immSrc = 2'b10;
            OP_JAL:  o_immSrc = 2'b11;
            default: o_immSrc = 2'b00;
        endcase
    end

    assign o_pcWrite  = pc_we  & i_rst_n;
    assign o_memWrite = mem_we & i_rst_n;
    assign o_irWrite  = ir_we  & i_rst_n;
    assign o_regWrite = reg_we & i_rst_n;

`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
    assign o_illegal = (cur == S_ERROR);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench: two controllers (no fetch wait / 3 fetch wait cycles) checked every cycle against
// an instruction-level schedule of expected control words built from the instruction class.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1000, XOR_ = 4'b0100, OR_ = 4'b0110, AND_ = 4'b0111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b0, rst1 = 1'b0;
    logic [6:0] opc0 = OP_LW, opc1 = OP_LW;
    logic [2:0] f30 = '0, f31 = '0;
    logic       f70 = 1'b0, f71 = 1'b0, z0 = 1'b0, z1 = 1'b0;
    logic       pcw0, memw0, irw0, regw0, adr0, pcw1, memw1, irw1, regw1, adr1;
    logic [1:0] res0, sa0, sb0, imm0, res1, sa1, sb1, imm1;
    logic [3:0] op0, op1;
    logic       ill0, ill1;

    int checks = 0;
    int failures = 0;
    logic [17:0] q0[$];
    logic [17:0] q1[$];

    multicycle_controller #(.FETCH_WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst0), .i_opcode(opc0), .i_funct3(f30), .i_funct7b5(f70),
        .i_zeroFlag(z0), .o_pcWrite(pcw0), .o_memWrite(memw0), .o_irWrite(irw0),
        .o_regWrite(regw0), .o_adrSrc(adr0), .o_resultSrc(res0), .o_aluSrcA(sa0),
        .o_aluSrcB(sb0), .o_immSrc(imm0), .o_aluLogicOperation(op0)
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
        , .o_illegal(ill0)
`endif
    );

    multicycle_controller #(.FETCH_WAIT_CYCLES(3)) dut1 (
        .i_clk(clk), .i_rst_n(rst1), .i_opcode(opc1), .i_funct3(f31), .i_funct7b5(f71),
        .i_zeroFlag(z1), .o_pcWrite(pcw1), .o_memWrite(memw1), .o_irWrite(irw1),
        .o_regWrite(regw1), .o_adrSrc(adr1), .o_resultSrc(res1), .o_aluSrcA(sa1),
        .o_aluSrcB(sb1), .o_immSrc(imm1), .o_aluLogicOperation(op1)
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
        , .o_illegal(ill1)
`endif
    );

`ifndef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
    assign ill0 = 1'b0;
    assign ill1 = 1'b0;
`endif

    // Control word layout: {illegal, pcW, memW, irW, regW, adrSrc, resultSrc, srcA, srcB, immSrc, aluOp}
    function automatic logic [17:0] rec(input logic ill, pcw, memw, irw, regw, adr,
                                        input logic [1:0] res, a, b, im, input logic [3:0] op);
        return {ill, pcw, memw, irw, regw, adr, res, a, b, im, op};
    endfunction

    function automatic logic [17:0] vec(input int d);
        if (d == 0) return {ill0, pcw0, memw0, irw0, regw0, adr0, res0, sa0, sb0, imm0, op0};
        return {ill1, pcw1, memw1, irw1, regw1, adr1, res1, sa1, sb1, imm1, op1};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] opc);
        if (opc == OP_SW)  return 2'b01;
        if (opc == OP_BEQ) return 2'b10;
        if (opc == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
        if (f3 == 3'b000) return (is_r && f7) ? SUB : ADD;
        if (f3 == 3'b100) return XOR_;
        if (f3 == 3'b110) return OR_;
        if (f3 == 3'b111) return AND_;
        return ADD;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic emit(input int d, input int lim, inout int n, input logic [17:0] v);
        if (n < lim) begin
            if (d == 0) q0.push_back(v);
            else        q1.push_back(v);
        end
        n++;
    endtask

    // Whole-instruction schedule of control words, truncated to lim cycles
    task automatic gen(input int d, input int w, input logic [6:0] opc, input logic [2:0] f3,
                       input logic f7, input logic z, input int lim, output int n);
        logic [1:0] im;
        im = imm_of(opc);
        n = 0;
        for (int i = 0; i < w; i++) emit(d, lim, n, rec(0,0,0,0,0,0,2'b10,2'b00,2'b10,im,ADD));
        emit(d, lim, n, rec(0,1,0,1,0,0,2'b10,2'b00,2'b10,im,ADD));
        emit(d, lim, n, rec(0,0,0,0,0,0,2'b00,2'b01,2'b01,im,ADD));
        case (opc)
            OP_LW: begin
                emit(d, lim, n, rec(0,0,0,0,0,0,2'b00,2'b10,2'b01,im,ADD));
                emit(d, lim, n, rec(0,0,0,0,0,1,2'b00,2'b00,2'b00,im,ADD));
                emit(d, lim, n, rec(0,0,0,0,1,0,2'b01,2'b00,2'b00,im,ADD));
            end
            OP_SW: begin
                emit(d, lim, n, rec(0,0,0,0,0,0,2'b00,2'b10,2'b01,im,ADD));
                emit(d, lim, n, rec(0,0,1,0,0,1,2'b00,2'b00,2'b00,im,ADD));
            end
            OP_R, OP_I: begin
                emit(d, lim, n, rec(0,0,0,0,0,0,2'b00,2'b10,(opc == OP_I) ? 2'b01 : 2'b00,im,
                                    alu_of(f3, f7, opc == OP_R)));
                emit(d, lim, n, rec(0,0,0,0,1,0,2'b00,2'b00,2'b00,im,ADD));
            end
            OP_BEQ: emit(d, lim, n, rec(0,z,0,0,0,0,2'b00,2'b10,2'b00,im,SUB));
            OP_JAL: begin
                emit(d, lim, n, rec(0,1,0,0,0,0,2'b00,2'b01,2'b10,im,ADD));
                emit(d, lim, n, rec(0,0,0,0,1,0,2'b00,2'b00,2'b00,im,ADD));
            end
            default: begin
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
                while (n < lim) emit(d, lim, n, rec(1,0,0,0,0,0,2'b00,2'b00,2'b00,im,ADD));
`endif
            end
        endcase
        if (n > lim) n = lim;
    endtask

    task automatic set_in(input int d, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic z, input logic rst);
        if (d == 0) begin opc0 = opc; f30 = f3; f70 = f7; z0 = z; rst0 = rst; end
        else        begin opc1 = opc; f31 = f3; f71 = f7; z1 = z; rst1 = rst; end
    endtask

    // Runs one instruction; cap holds the DUT control word seen in cycle `probe` (1-based)
    task automatic run(input int d, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic z, input int lim, input int probe,
                       output int n, output logic [17:0] cap);
        set_in(d, opc, f3, f7, z, 1'b1);
        gen(d, (d == 0) ? 0 : 3, opc, f3, f7, z, lim, n);
        cap = '0;
        for (int c = 1; c <= n; c++) begin
            if (c == probe) begin @(negedge clk); cap = vec(d); end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int d, input int cyc, input logic [6:0] opc);
        set_in(d, opc, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < cyc; c++) begin
            if (d == 0) q0.push_back(rec(0,0,0,0,0,0,2'b10,2'b00,2'b10,imm_of(opc),ADD));
            else        q1.push_back(rec(0,0,0,0,0,0,2'b10,2'b00,2'b10,imm_of(opc),ADD));
        end
        repeat (cyc) begin @(posedge clk); #1; end
    endtask

    // Per-cycle comparison of both DUTs against the scheduled control words
    always @(negedge clk) begin
        if (q0.size() > 0) chk("dut0_ctrl", 32'(vec(0)), 32'(q0.pop_front()));
        if (q1.size() > 0) chk("dut1_ctrl", 32'(vec(1)), 32'(q1.pop_front()));
    end

    task automatic drive0();
        int n;
        logic [17:0] cap;
        do_reset(0, 2, OP_LW);
        run(0, OP_LW, 3'b010, 0, 0, 100, 5, n, cap);
        chk("lw_cycles", n, 5);
        chk("lw_regwrite_c5", cap[13], 1);
        run(0, OP_SW, 3'b010, 0, 0, 100, 4, n, cap);
        chk("sw_cycles", n, 4);
        chk("sw_memwrite_c4", cap[15], 1);
        run(0, OP_R, 3'b000, 1, 0, 100, 3, n, cap);
        chk("r_sub_cycles", n, 4);
        chk("r_sub_aluop", cap[3:0], 4'b1000);
        run(0, OP_I, 3'b000, 1, 0, 100, 3, n, cap);
        chk("i_add_aluop", cap[3:0], 4'b0000);
        run(0, OP_R, 3'b100, 0, 0, 100, 3, n, cap);
        chk("r_xor_aluop", cap[3:0], 4'b0100);
        run(0, OP_I, 3'b110, 1, 0, 100, 3, n, cap);
        chk("i_or_aluop", cap[3:0], 4'b0110);
        run(0, OP_R, 3'b111, 0, 1, 100, 3, n, cap);
        chk("r_and_aluop", cap[3:0], 4'b0111);
        run(0, OP_R, 3'b001, 1, 0, 100, 0, n, cap);
        run(0, OP_BEQ, 3'b000, 0, 1, 100, 3, n, cap);
        chk("beq_cycles", n, 3);
        chk("beq_taken_pcw", cap[16], 1);
        run(0, OP_BEQ, 3'b000, 0, 0, 100, 3, n, cap);
        chk("beq_not_taken_pcw", cap[16], 0);
        run(0, OP_JAL, 3'b000, 0, 0, 100, 3, n, cap);
        chk("jal_cycles", n, 4);
        chk("jal_immsrc", cap[5:4], 2'b11);
        run(0, OP_SW, 3'b010, 0, 0, 3, 0, n, cap);
        do_reset(0, 1, OP_SW);
        run(0, OP_LW, 3'b010, 0, 0, 100, 0, n, cap);
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
        run(0, OP_BAD, 3'b000, 0, 0, 6, 6, n, cap);
        chk("illegal_flag", cap[17], 1);
        do_reset(0, 1, OP_BAD);
`else
        run(0, OP_BAD, 3'b000, 0, 0, 100, 2, n, cap);
        chk("bad_op_cycles", n, 2);
`endif
        run(0, OP_R, 3'b000, 0, 0, 100, 0, n, cap);
    endtask

    task automatic drive1();
        int n;
        logic [17:0] cap;
        do_reset(1, 2, OP_LW);
        run(1, OP_LW, 3'b010, 0, 0, 100, 4, n, cap);
        chk("wait3_lw_cycles", n, 8);
        chk("wait3_irwrite_c4", cap[14], 1);
        run(1, OP_BEQ, 3'b000, 0, 1, 100, 3, n, cap);
        chk("wait3_irwrite_c3", cap[14], 0);
        run(1, OP_R, 3'b000, 1, 0, 100, 0, n, cap);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        fork
            drive0();
            drive1();
        join
        repeat (2) @(posedge clk);
        chk("schedule_drained", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter FETCH_WAIT_CYCLES, default 0, meaning: extra instruction-memory wait cycles inserted in FETCH (range 0..15).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_opcode  input  7  instruction[6:0] from instruction register.
REQ-005 i_funct3  input  3  instruction[14:12].
REQ-006 i_funct7b5  input  1  instruction[30].
REQ-007 i_zeroFlag  input  1  ALU result == 0, same cycle as current ALU operation.
REQ-008 o_pcWrite, o_memWrite, o_irWrite, o_regWrite  output  1 each  write enables.
REQ-009 o_adrSrc  output  1  memory address select: 0=PC, 1=ALU-out register.
REQ-010 o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc  output  2 each  datapath mux selects.
REQ-011 o_aluLogicOperation  output  4  ALU operation code driven to the ALU.
REQ-012 o_illegal  output  1  sticky illegal-instruction flag (present only under REQ-034).

Function
REQ-013 ALU codes SHALL be ADD=4'b0000, SUB=4'b1000, XOR=4'b0100, OR=4'b0110, AND=4'b0111; bit 3 set only for SUB.
REQ-014 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL (plus ERROR, REQ-034); all outputs decode from state only, except o_pcWrite in BEQ.
REQ-015 Unlisted outputs per state SHALL be 0; o_aluLogicOperation defaults to ADD.
REQ-016 FETCH: adrSrc=0, aluSrcA=00 (PC), aluSrcB=10 (const 4), ADD, resultSrc=10; irWrite=pcWrite=1 only on the final FETCH cycle; then DECODE.
REQ-017 FETCH lasts FETCH_WAIT_CYCLES+1 cycles, counted by an internal counter cleared on leaving FETCH.
REQ-018 DECODE: aluSrcA=01 (old PC), aluSrcB=01 (imm), ADD; next by opcode: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, other->FETCH.
REQ-019 MEMADR: aluSrcA=10 (rs1), aluSrcB=01, ADD; next MEMREAD if opcode 0000011, else MEMWRITE.
REQ-020 MEMREAD: resultSrc=00, adrSrc=1 -> MEMWB. MEMWB: resultSrc=01, regWrite=1 -> FETCH.
REQ-021 MEMWRITE: resultSrc=00, adrSrc=1, memWrite=1 -> FETCH.
REQ-022 EXECUTER: aluSrcA=10, aluSrcB=00, op per REQ-026 -> ALUWB. EXECUTEI: aluSrcA=10, aluSrcB=01, op per REQ-027 -> ALUWB.
REQ-023 ALUWB: resultSrc=00, regWrite=1 -> FETCH.
REQ-024 BEQ: aluSrcA=10, aluSrcB=00, SUB, resultSrc=00, o_pcWrite=i_zeroFlag (combinational) -> FETCH.
REQ-025 JAL: aluSrcA=01, aluSrcB=10, ADD, resultSrc=00, pcWrite=1 -> ALUWB.
REQ-026 R-type op: funct3 000 -> SUB if funct7b5 else ADD; 100 XOR; 110 OR; 111 AND; other ADD.
REQ-027 I-type op: as REQ-026 but funct3 000 always ADD regardless of funct7b5.
REQ-028 o_immSrc combinational from i_opcode in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-029 Instruction cycle counts (FETCH_WAIT_CYCLES=0): lw 5, sw 4, R/I 4, beq 3, jal 4.

Reset
REQ-030 i_rst_n sampled low at a rising edge SHALL force state=FETCH and counter=0 on that edge, regardless of current state.
REQ-031 While i_rst_n is low all write enables SHALL be 0 (combinational gating); selects follow FETCH values.
REQ-032 First cycle after reset release is FETCH cycle 1; reset mid-instruction aborts it with no further writes.
REQ-033 o_illegal resets to 0.

Configuration
REQ-034 Macro MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN: defined -> undefined opcode in DECODE goes to ERROR (all enables 0, o_illegal=1), held until reset; undefined -> undefined opcode returns to FETCH, no o_illegal port, ERROR state absent.

Verification
REQ-035 Reset held 2 cycles then released, opcode 0000011 -> state sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regWrite=1 only in cycle 5.
REQ-036 R-type funct3=000 funct7b5=1 -> o_aluLogicOperation=4'b1000 in EXECUTER; I-type same fields -> 4'b0000 in EXECUTEI.
REQ-037 beq with i_zeroFlag=1 in BEQ -> o_pcWrite=1; with i_zeroFlag=0 -> o_pcWrite=0; both next FETCH.
REQ-038 FETCH_WAIT_CYCLES=3 -> FETCH lasts 4 cycles, irWrite/pcWrite pulse once on cycle 4.
REQ-039 Reset asserted during MEMWRITE -> memWrite 0 that cycle, state FETCH next edge.
REQ-040 Opcode 1111111 with macro -> ERROR, o_illegal=1 until reset; without -> FETCH after DECODE.
